// File: rtl/jtag_dma_engine.sv
// Block DMA between the JTAG ping-pong buffer and the Gecko5 shared bus.
// Blocks are split into bursts of at most MAX_BURST words.
module jtag_dma_engine #(
  parameter int BUF_ADDR_W = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic                  system_clk,
  input  logic                  system_rstn,
  input  logic                  launch_read,
  input  logic                  launch_write,
  input  logic [31:0]           start_address,
  input  logic [3:0]            byte_enable,
  input  logic [7:0]            burst_size_in,
  input  logic [7:0]            block_size_in,
  output logic                  dma_busy,
  output logic [7:0]            words_done,
  output logic                  dma_error,
  output logic [BUF_ADDR_W-1:0] buf_address,
  output logic                  buf_write_enable,
  output logic [31:0]           buf_data_out,
  input  logic [31:0]           buf_data_in,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic                  begin_transaction_out,
  output logic                  end_transaction_out,
  output logic [31:0]           address_data_out,
  output logic [3:0]            byte_enables_out,
  output logic [7:0]            burst_size_out,
  output logic                  read_n_write_out,
  output logic                  data_valid_out,
  input  logic [31:0]           address_data_in,
  input  logic                  data_valid_in,
  input  logic                  end_transaction_in,
  input  logic                  busy_in,
  input  logic                  error_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BEGIN, S_RD, S_WR, S_WEND, S_NEXT
  } state_t;

  state_t state, state_nx;

  logic [31:0]           addr;
  logic [3:0]            be;
  logic                  dir_rd;
  logic                  err;
  logic [8:0]            n_words;
  logic [8:0]            b_max;
  logic [8:0]            blen;
  logic [8:0]            beats;
  logic [8:0]            done;
  logic [BUF_ADDR_W-1:0] idx;

  logic       launch;
  logic [8:0] remain;
  logic [8:0] cur_len;
  logic       rd_beat;
  logic       wr_beat;
  logic       last_wr;
  logic       abort;

  assign launch  = (state == S_IDLE) && (launch_read || launch_write);
  assign remain  = n_words - done;
  assign cur_len = (remain < b_max) ? remain : b_max;
  assign rd_beat = (state == S_RD) && data_valid_in && !error_in;
  assign wr_beat = (state == S_WR) && !busy_in && !error_in;
  assign last_wr = wr_beat && (beats == blen - 9'd1);
  assign abort   = (state != S_IDLE) && error_in;

  always_ff @(posedge system_clk or negedge system_rstn) begin
    if (!system_rstn) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (launch) state_nx = S_REQ;
        S_REQ:   if (bus_grant) state_nx = S_BEGIN;
        S_BEGIN: state_nx = dir_rd ? S_RD : S_WR;
        S_RD:    if (end_transaction_in) state_nx = S_NEXT;
        S_WR:    if (last_wr) state_nx = S_WEND;
        S_WEND:  state_nx = S_NEXT;
        S_NEXT:  state_nx = (done < n_words) ? S_REQ : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_request           = 1'b0;
    begin_transaction_out = 1'b0;
    end_transaction_out   = 1'b0;
    address_data_out      = 32'd0;
    byte_enables_out      = 4'd0;
    burst_size_out        = 8'd0;
    read_n_write_out      = 1'b0;
    data_valid_out        = 1'b0;
    buf_write_enable      = 1'b0;
    buf_data_out          = 32'd0;
    // the RAM reads one cycle ahead, so step its address as a beat is taken
    buf_address           = wr_beat ? idx + 1'b1 : idx;
    unique case (state)
      S_REQ: bus_request = !error_in;
      S_BEGIN: begin
        bus_request           = !error_in;
        begin_transaction_out = 1'b1;
        address_data_out      = addr;
        byte_enables_out      = be;
        burst_size_out        = cur_len[7:0] - 8'd1;
        read_n_write_out      = dir_rd;
      end
      S_RD: begin
        bus_request         = !error_in;
        end_transaction_out = error_in;
        buf_write_enable    = rd_beat;
        buf_data_out        = rd_beat ? address_data_in : 32'd0;
      end
      S_WR: begin
        bus_request         = !error_in;
        end_transaction_out = error_in;
        data_valid_out      = !error_in;
        address_data_out    = error_in ? 32'd0 : buf_data_in;
      end
      S_WEND: begin
        bus_request         = !error_in;
        end_transaction_out = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_rstn) begin
    if (!system_rstn) begin
      addr    <= 32'd0;
      be      <= 4'd0;
      dir_rd  <= 1'b0;
      err     <= 1'b0;
      n_words <= 9'd0;
      b_max   <= 9'd0;
      blen    <= 9'd0;
      beats   <= 9'd0;
      done    <= 9'd0;
      idx     <= '0;
    end else begin
      if (launch) begin
        addr    <= start_address;
        be      <= byte_enable;
        dir_rd  <= launch_read;
        err     <= 1'b0;
        n_words <= {1'b0, block_size_in} + 9'd1;
        b_max   <= ({1'b0, burst_size_in} >= 9'(MAX_BURST - 1)) ?
                   9'(MAX_BURST) : {1'b0, burst_size_in} + 9'd1;
        done    <= 9'd0;
        idx     <= '0;
      end
      if (abort) err <= 1'b1;
      if (state == S_BEGIN) begin
        blen  <= cur_len;
        beats <= 9'd0;
      end
      if (rd_beat || wr_beat) begin
        idx  <= idx + 1'b1;
        done <= done + 9'd1;
      end
      if (wr_beat) beats <= beats + 9'd1;
      if (state == S_NEXT) addr <= addr + {21'd0, blen, 2'b00};
    end
  end

  assign dma_busy   = (state != S_IDLE);
  assign words_done = done[7:0];
  assign dma_error  = err;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Directed bench for jtag_dma_engine with a bus slave and
// a synchronous-read buffer model.
module tb_jtag_dma_engine;

  logic        system_clk = 1'b0;
  logic        system_rstn = 1'b0;
  logic        launch_read = 1'b0;
  logic        launch_write = 1'b0;
  logic [31:0] start_address = '0;
  logic [3:0]  byte_enable = '0;
  logic [7:0]  burst_size_in = '0;
  logic [7:0]  block_size_in = '0;
  logic        dma_busy;
  logic [7:0]  words_done;
  logic        dma_error;
  logic [8:0]  buf_address;
  logic        buf_write_enable;
  logic [31:0] buf_data_out;
  logic [31:0] buf_data_in = '0;
  logic        bus_request;
  logic        bus_grant = 1'b0;
  logic        begin_transaction_out;
  logic        end_transaction_out;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        data_valid_out;
  logic [31:0] address_data_in = '0;
  logic        data_valid_in = 1'b0;
  logic        end_transaction_in = 1'b0;
  logic        busy_in = 1'b0;
  logic        error_in = 1'b0;

  int cmp = 0;
  int bad = 0;
  logic [31:0] mem [0:511];

  always #5 system_clk = ~system_clk;

  always @(posedge system_clk) begin
    if (buf_write_enable) mem[buf_address] <= buf_data_out;
    buf_data_in <= mem[buf_address];
  end

  jtag_dma_engine #(.BUF_ADDR_W(9), .MAX_BURST(16)) dut (
    .system_clk(system_clk), .system_rstn(system_rstn),
    .launch_read(launch_read), .launch_write(launch_write),
    .start_address(start_address), .byte_enable(byte_enable),
    .burst_size_in(burst_size_in), .block_size_in(block_size_in),
    .dma_busy(dma_busy), .words_done(words_done),
    .dma_error(dma_error), .buf_address(buf_address),
    .buf_write_enable(buf_write_enable),
    .buf_data_out(buf_data_out), .buf_data_in(buf_data_in),
    .bus_request(bus_request), .bus_grant(bus_grant),
    .begin_transaction_out(begin_transaction_out),
    .end_transaction_out(end_transaction_out),
    .address_data_out(address_data_out),
    .byte_enables_out(byte_enables_out),
    .burst_size_out(burst_size_out),
    .read_n_write_out(read_n_write_out),
    .data_valid_out(data_valid_out),
    .address_data_in(address_data_in),
    .data_valid_in(data_valid_in),
    .end_transaction_in(end_transaction_in),
    .busy_in(busy_in), .error_in(error_in)
  );

  function automatic logic [127:0] all_outs();
    return {dma_busy, words_done, dma_error, buf_address,
            buf_write_enable, buf_data_out, bus_request,
            begin_transaction_out, end_transaction_out,
            address_data_out, byte_enables_out, burst_size_out,
            read_n_write_out, data_valid_out};
  endfunction

  task automatic do_launch(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [3:0] be,
                           input logic [7:0] bs, input logic [7:0] blk);
    @(negedge system_clk);
    launch_read = rd; launch_write = wr;
    start_address = a; byte_enable = be;
    burst_size_in = bs; block_size_in = blk;
    @(negedge system_clk);
    launch_read = 1'b0; launch_write = 1'b0;
  endtask

  // grants the bus and captures the begin cycle; ok=0 on timeout
  task automatic bus_begin(output logic [31:0] a, output logic [7:0] bs,
                           output logic [3:0] be, output logic rnw,
                           output logic ok);
    ok = 1'b0; a = '0; bs = '0; be = '0; rnw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge system_clk); #1;
      if (bus_request) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    bus_grant = 1'b1;
    @(negedge system_clk);
    bus_grant = 1'b0;
    #1;
    ok = begin_transaction_out;
    a = address_data_out; bs = burst_size_out;
    be = byte_enables_out; rnw = read_n_write_out;
  endtask

  task automatic read_beats(input logic [31:0] d0, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge system_clk);
      data_valid_in = 1'b1; address_data_in = d0 + k;
    end
    @(negedge system_clk);
    data_valid_in = 1'b0; address_data_in = '0; end_transaction_in = 1'b1;
    @(negedge system_clk);
    end_transaction_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge system_clk); #1;
      if (!dma_busy) break;
    end
  endtask

  task automatic test_reset();
    #1;
    cmp++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    @(negedge system_clk); system_rstn = 1'b1;
    @(negedge system_clk); #1;
    cmp++;
    if (dma_busy !== 1'b0 || bus_request !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy %b req %b want 0 0",
                      dma_busy, bus_request);
    end
  endtask

  task automatic test_read_block();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    do_launch(1'b1, 1'b0, 32'h1000, 4'hF, 8'd3, 8'd7);
    for (int b = 0; b < 2; b++) begin
      bus_begin(a, bs, be, rnw, ok);
      cmp++;
      if (ok !== 1'b1 || a !== 32'h1000 + 32'(16 * b) || bs !== 8'd3 ||
          rnw !== 1'b1 || be !== 4'hF) begin
        bad++;
        $display("FAIL rd_begin%0d: ok %b a %h bs %0d rnw %b be %h want 1 %h 3 1 f",
                 b, ok, a, bs, rnw, be, 32'h1000 + 32'(16 * b));
      end
      read_beats(32'hA0 + 32'(4 * b), 4);
    end
    wait_idle();
    cmp++;
    if (dma_busy !== 1'b0 || words_done !== 8'd8) begin
      bad++; $display("FAIL rd_done: busy %b words %0d want 0 8",
                      dma_busy, words_done);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (mem[i] !== 32'hA0 + 32'(i)) begin
        bad++; $display("FAIL rd_buf%0d: got %h want %h",
                        i, mem[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_write_stall();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    int kseq[7] = '{0, 1, 1, 2, 3, 3, 4};
    logic sseq[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) mem[i] = 32'hB0 + 32'(i);
    do_launch(1'b0, 1'b1, 32'h2000, 4'h3, 8'd15, 8'd4);
    bus_begin(a, bs, be, rnw, ok);
    cmp++;
    if (ok !== 1'b1 || a !== 32'h2000 || bs !== 8'd4 ||
        rnw !== 1'b0 || be !== 4'h3) begin
      bad++; $display("FAIL wr_begin: ok %b a %h bs %0d rnw %b be %h want 1 2000 4 0 3",
                      ok, a, bs, rnw, be);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge system_clk);
      busy_in = sseq[c];
      #1;
      cmp++;
      if (data_valid_out !== 1'b1 || end_transaction_out !== 1'b0 ||
          address_data_out !== 32'hB0 + 32'(kseq[c])) begin
        bad++; $display("FAIL wr_beat_c%0d: dv %b end %b data %h want 1 0 %h",
                        c, data_valid_out, end_transaction_out,
                        address_data_out, 32'hB0 + 32'(kseq[c]));
      end
    end
    @(negedge system_clk);
    busy_in = 1'b0;
    #1;
    cmp++;
    if (end_transaction_out !== 1'b1 || data_valid_out !== 1'b0) begin
      bad++; $display("FAIL wr_end: end %b dv %b want 1 0",
                      end_transaction_out, data_valid_out);
    end
    wait_idle();
    cmp++;
    if (dma_busy !== 1'b0 || words_done !== 8'd5) begin
      bad++; $display("FAIL wr_done: busy %b words %0d want 0 5",
                      dma_busy, words_done);
    end
  endtask

  task automatic test_remainder();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    logic [7:0] exp_bs[3] = '{8'd3, 8'd3, 8'd1};
    int n[3] = '{4, 4, 2};
    do_launch(1'b1, 1'b0, 32'h3000, 4'hF, 8'd3, 8'd9);
    for (int b = 0; b < 3; b++) begin
      bus_begin(a, bs, be, rnw, ok);
      cmp++;
      if (ok !== 1'b1 || a !== 32'h3000 + 32'(16 * b) || bs !== exp_bs[b]) begin
        bad++; $display("FAIL rem_begin%0d: ok %b a %h bs %0d want 1 %h %0d",
                        b, ok, a, bs, 32'h3000 + 32'(16 * b), exp_bs[b]);
      end
      read_beats(32'hC0 + 32'(4 * b), n[b]);
    end
    wait_idle();
    cmp++;
    if (dma_busy !== 1'b0 || words_done !== 8'd10 || mem[9] !== 32'hC9) begin
      bad++; $display("FAIL rem_done: busy %b words %0d buf9 %h want 0 10 c9",
                      dma_busy, words_done, mem[9]);
    end
  endtask

  task automatic test_error();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    do_launch(1'b1, 1'b0, 32'h6000, 4'hF, 8'd15, 8'd3);
    bus_begin(a, bs, be, rnw, ok);
    cmp++;
    if (ok !== 1'b1 || bs !== 8'd3) begin
      bad++; $display("FAIL err_begin: ok %b bs %0d want 1 3", ok, bs);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge system_clk);
      data_valid_in = 1'b1; address_data_in = 32'hE0 + 32'(k);
    end
    @(negedge system_clk);
    address_data_in = 32'hE2; error_in = 1'b1;
    #1;
    cmp++;
    if (end_transaction_out !== 1'b1 || bus_request !== 1'b0 ||
        buf_write_enable !== 1'b0) begin
      bad++; $display("FAIL err_abort: end %b req %b we %b want 1 0 0",
                      end_transaction_out, bus_request, buf_write_enable);
    end
    @(negedge system_clk);
    error_in = 1'b0; data_valid_in = 1'b0; address_data_in = '0;
    #1;
    cmp++;
    if (dma_busy !== 1'b0 || dma_error !== 1'b1 || words_done !== 8'd2 ||
        end_transaction_out !== 1'b0) begin
      bad++; $display("FAIL err_state: busy %b err %b words %0d end %b want 0 1 2 0",
                      dma_busy, dma_error, words_done, end_transaction_out);
    end
  endtask

  task automatic test_launch_rules();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    do_launch(1'b1, 1'b1, 32'h4000, 4'h5, 8'd1, 8'd1);
    #1;
    cmp++;
    if (dma_error !== 1'b0 || dma_busy !== 1'b1) begin
      bad++; $display("FAIL relaunch: err %b busy %b want 0 1",
                      dma_error, dma_busy);
    end
    do_launch(1'b0, 1'b1, 32'h5000, 4'hA, 8'd7, 8'd7);
    bus_begin(a, bs, be, rnw, ok);
    cmp++;
    if (ok !== 1'b1 || a !== 32'h4000 || bs !== 8'd1 ||
        rnw !== 1'b1 || be !== 4'h5) begin
      bad++; $display("FAIL both_begin: ok %b a %h bs %0d rnw %b be %h want 1 4000 1 1 5",
                      ok, a, bs, rnw, be);
    end
    read_beats(32'hD0, 2);
    wait_idle();
    cmp++;
    if (dma_busy !== 1'b0 || words_done !== 8'd2 || mem[1] !== 32'hD1) begin
      bad++; $display("FAIL both_done: busy %b words %0d buf1 %h want 0 2 d1",
                      dma_busy, words_done, mem[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a; logic [7:0] bs; logic [3:0] be; logic rnw, ok;
    do_launch(1'b0, 1'b1, 32'h7000, 4'hF, 8'd3, 8'd7);
    bus_begin(a, bs, be, rnw, ok);
    @(negedge system_clk); #1;
    cmp++;
    if (ok !== 1'b1 || data_valid_out !== 1'b1) begin
      bad++; $display("FAIL mid_wr_setup: ok %b dv %b want 1 1",
                      ok, data_valid_out);
    end
    @(negedge system_clk);
    system_rstn = 1'b0;
    #1;
    cmp++;
    if (all_outs() !== '0 || end_transaction_out !== 1'b0) begin
      bad++; $display("FAIL mid_wr_reset: got %h want 0", all_outs());
    end
    @(negedge system_clk);
    system_rstn = 1'b1;
    repeat (3) @(negedge system_clk);
    #1;
    cmp++;
    if (dma_busy !== 1'b0 || bus_request !== 1'b0 || words_done !== 8'd0) begin
      bad++; $display("FAIL mid_wr_idle: busy %b req %b words %0d want 0 0 0",
                      dma_busy, bus_request, words_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_read_block();
    test_write_stall();
    test_remainder();
    test_error();
    test_launch_rules();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/jtag_dma_engine.md
Name: jtag_dma_engine

Overview:
System-clock-side DMA engine fed by the JTAG ip core's DMA command outputs. On a launch pulse it moves a block of 32-bit words between the ping-pong buffer's system-side port and the Gecko5 shared bus, splitting the block into bursts. "Read" means bus memory → buffer. "Write" means buffer → bus memory. It returns busy, a transferred-word count and an error flag to the ip core.

Parameters:
BUF_ADDR_W, 9, ping-pong buffer word-address width
MAX_BURST, 16, hard cap on words per bus burst

Ports:
system_clk  in  1  system clock; all logic on rising edge
system_rstn  in  1  asynchronous active-low reset
launch_read  in  1  one-cycle start pulse, bus→buffer
launch_write  in  1  one-cycle start pulse, buffer→bus
start_address  in  32  first bus byte address, word aligned
byte_enable  in  4  byte enables for every beat
burst_size_in  in  8  requested words per burst minus 1
block_size_in  in  8  total words minus 1
dma_busy  out  1  high from launch acceptance until done/abort
words_done  out  8  words completed in the current/last block
dma_error  out  1  sticky bus error, cleared on next accepted launch
buf_address  out  BUF_ADDR_W  buffer word index
buf_write_enable  out  1  buffer write strobe
buf_data_out  out  32  data written to buffer
buf_data_in  in  32  buffer read data, 1-cycle latency
bus_request  out  1  bus request
bus_grant  in  1  bus grant
begin_transaction_out  out  1  one-cycle transaction start
end_transaction_out  out  1  one-cycle write-transaction end / abort
address_data_out  out  32  address on begin, data on write beats
byte_enables_out  out  4  valid with begin
burst_size_out  out  8  beats minus 1, valid with begin
read_n_write_out  out  1  1 = bus read
data_valid_out  out  1  write beat valid
address_data_in  in  32  read data
data_valid_in  in  1  read beat valid
end_transaction_in  in  1  slave ends read burst
busy_in  in  1  slave stall, write beat held
error_in  in  1  bus error

Behaviour:
- Reset (async, immediate): state IDLE; every output 0; counters and latched parameters 0. Reset mid-transfer abandons the transfer with no end_transaction.
- Launch is accepted only in IDLE. If launch_read and launch_write are high together, read wins. Launch while dma_busy is ignored.
- On acceptance:
  - latch start_address, byte_enable, direction, N = block_size_in+1, B = min(burst_size_in+1, MAX_BURST);
  - clear words_done, dma_error and buffer index;
  - dma_busy=1 from the next cycle.
- States and transitions:
  - IDLE → REQUEST on an accepted launch.
  - REQUEST: bus_request=1; on bus_grant → BEGIN.
  - BEGIN: exactly 1 cycle. begin_transaction_out=1; address_data_out=current address; burst_size_out=L-1, where L=min(B, N-words_done); read_n_write_out per direction; byte_enables_out latched. Then → READ_BEATS or WRITE_BEATS.
  - READ_BEATS: each cycle with data_valid_in=1:
    - buf_write_enable=1, buf_data_out=address_data_in, buf_address=index;
    - index++, words_done++.
    - On end_transaction_in → NEXT.
  - WRITE_BEATS:
    - buffer read issued one cycle ahead of each beat;
    - data_valid_out=1 with address_data_out=buffer word;
    - while busy_in=1 the beat and its data are held unchanged; a beat counts only when busy_in=0;
    - after L beats, end_transaction_out=1 for 1 cycle → NEXT.
  - NEXT: bus_request=0; address += 4*L (32-bit wrap); → REQUEST if words_done<N, else → IDLE with dma_busy=0.
- Buffer index wraps modulo 2^BUF_ADDR_W. It is not reset between bursts of one block.
- error_in in any bus state:
  - drop request;
  - end_transaction_out=1 for 1 cycle if a transaction is open;
  - dma_error=1, → IDLE.
  - words_done keeps the beats already completed.
- bus_request never drops between grant and burst end. No beat is issued before begin_transaction_out.

Test Plan:
- Reset mid-WRITE_BEATS: assert system_rstn=0 → all outputs 0 in the same cycle, no end_transaction_out; after release, state is IDLE.
- Read block: start 0x1000, burst 3, block 7; slave returns 8 words 0xA0..0xA7 → two begins at 0x1000 and 0x1010, each with burst_size_out=3; buffer indices 0..7 written with 0xA0..0xA7; words_done=8; dma_busy falls.
- Write with stalls: buffer holds 0xB0..0xB4, block 4, burst 15, busy_in high on beats 2 and 4 → one burst_size_out=4; beats 0xB0..0xB4 in order, each held while stalled; end_transaction_out after the 5th beat.
- Remainder burst: block 9, burst 3 → bursts of 4, 4, 2 with burst_size_out 3, 3, 1.
- Error: error_in on the 3rd read beat of a 4-word burst → end_transaction_out pulse, dma_error=1, words_done=2, next launch clears dma_error.
- Simultaneous launch_read and launch_write in IDLE → a read is performed; a launch pulse while busy → ignored, parameters unchanged.
